program_sequencer: RTL and testbench



---
 rtl/ps_pkg.sv | 10 +
 rtl/program_sequencer_if.sv | 32 +++
 rtl/ps_debug_fsm.sv | 62 ++++++
 rtl/program_sequencer.sv | 52 +++++
 tb/tb_program_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ps_pkg.sv
// Shared types and constants for the program sequencer slice.
package ps_pkg;
   localparam int unsigned PC_W = 8;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      STEP   = 2'd2
   } ps_state_e;
endpackage

// File: rtl/program_sequencer_if.sv
// Decoder/debug-side signal bundle of the program sequencer.
interface program_sequencer_if
   import ps_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);
   logic             jmp;
   logic             jmp_nz;
   logic [3:0]       jmp_addr;
   logic             dont_jmp;
   logic             halt_req;
   logic             run_req;
   logic             step_req;
   logic             bp_en;
   logic [PC_W-1:0]  bp_addr;
   logic [PC_W-1:0]  pm_addr;
   logic [PC_W-1:0]  pc;
   logic             hold;
   logic             halted;
   logic             step_ack;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output jmp, jmp_nz, jmp_addr, dont_jmp, halt_req, run_req, step_req, bp_en, bp_addr,
      input  pm_addr, pc, hold, halted, step_ack, instr_count
   );

   modport slave (
      input  jmp, jmp_nz, jmp_addr, dont_jmp, halt_req, run_req, step_req, bp_en, bp_addr,
      output pm_addr, pc, hold, halted, step_ack, instr_count
   );
endinterface

// File: rtl/ps_debug_fsm.sv
// Run-control FSM: halt/run/step, step edge detect and breakpoint arming.
module ps_debug_fsm
   import ps_pkg::*;
(
   input  logic            clk,
   input  logic            sync_reset_n,
   input  logic            halt_req,
   input  logic            run_req,
   input  logic            step_req,
   input  logic            bp_en,
   input  logic [PC_W-1:0] bp_addr,
   input  logic [PC_W-1:0] pc,
   output logic            hold,
   output logic            halted,
   output logic            step_ack
);
   ps_state_e       state_q, state_d;
   logic            step_q;
   logic            bp_armed;
   logic [PC_W-1:0] halt_pc;
   logic            bp_hit;

   always_comb begin
      state_d  = state_q;
      bp_hit   = 1'b0;
      hold     = (state_q == HALTED);
      halted   = (state_q == HALTED);
      step_ack = (state_q == STEP);
      case (state_q)
         RUN: begin
            bp_hit = bp_en && bp_armed && (pc == bp_addr);
            if (halt_req || bp_hit) state_d = HALTED;
         end
         HALTED: begin
            if (halt_req)                state_d = HALTED;
            else if (run_req)            state_d = RUN;
            else if (step_req && !step_q) state_d = STEP;
         end
         STEP:    state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state_q  <= RUN;
         step_q   <= 1'b0;
         bp_armed <= 1'b1;
         halt_pc  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_req;
         // Stay disarmed until the fetch address has moved off the trigger address.
         if (bp_hit) begin
            bp_armed <= 1'b0;
            halt_pc  <= pc;
         end else if (!bp_armed && (pc != halt_pc)) begin
            bp_armed <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetch address mux, program counter and retired-instruction counter.
module program_sequencer
   import ps_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)(
   input  logic                clk,
   input  logic                sync_reset_n,
   program_sequencer_if.slave  bus
);
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pm_addr_d;
   logic [CNT_W-1:0] cnt_q;
   logic             hold;

   ps_debug_fsm u_debug_fsm (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .halt_req     (bus.halt_req),
      .run_req      (bus.run_req),
      .step_req     (bus.step_req),
      .bp_en        (bus.bp_en),
      .bp_addr      (bus.bp_addr),
      .pc           (pc_q),
      .hold         (hold),
      .halted       (bus.halted),
      .step_ack     (bus.step_ack)
   );

   // Jump targets stay within the current 16-instruction page.
   always_comb begin
      if (!sync_reset_n)                              pm_addr_d = '0;
      else if (hold)                                  pm_addr_d = pc_q;
      else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) pm_addr_d = {pc_q[PC_W-1:4], bus.jmp_addr};
      else                                            pm_addr_d = pc_q + PC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         pc_q  <= '0;
         cnt_q <= '0;
      end else begin
         pc_q <= pm_addr_d;
         if (!hold && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.pm_addr     = pm_addr_d;
   assign bus.pc          = pc_q;
   assign bus.hold        = hold;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Randomized + directed scoreboard bench for program_sequencer against a flag-based reference model.
module tb_program_sequencer;
   localparam int unsigned CW   = 6;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic sync_reset_n;
   always #5 clk = ~clk;

   program_sequencer_if #(.CNT_W(CW)) psif ();

   program_sequencer #(.CNT_W(CW)) dut (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .bus          (psif.slave)
   );

   typedef struct {
      logic [7:0]  pm;
      logic [7:0]  pc;
      logic        hold;
      logic        halted;
      logic        ack;
      int unsigned cnt;
   } exp_t;

   exp_t sb[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // stimulus shadows
   logic       r_rst, r_jmp, r_jnz, r_dz, r_halt, r_run, r_step, r_bpen;
   logic [3:0] r_ja;
   logic [7:0] r_bpa;

   // reference model: "halted"/"stepping" flags, armed flag, trigger pc
   logic [7:0]  m_pc;
   int unsigned m_cnt;
   bit          m_halted, m_stepping, m_armed, m_prev_step;
   logic [7:0]  m_trig_pc;

   task automatic idle();
      r_rst = 1'b1; r_jmp = 1'b0; r_jnz = 1'b0; r_dz = 1'b0; r_ja = 4'h0;
      r_halt = 1'b0; r_run = 1'b0; r_step = 1'b0;
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_cnt = 0; m_halted = 0; m_stepping = 0;
      m_armed = 1; m_prev_step = 0; m_trig_pc = 8'h00;
   endtask

   task automatic tick();
      exp_t e;
      bit   running, hit;
      @(negedge clk);
      sync_reset_n  = r_rst;
      psif.jmp      = r_jmp;  psif.jmp_nz  = r_jnz; psif.jmp_addr = r_ja;
      psif.dont_jmp = r_dz;   psif.halt_req = r_halt; psif.run_req = r_run;
      psif.step_req = r_step; psif.bp_en   = r_bpen; psif.bp_addr = r_bpa;
      #1;
      if (!r_rst)                   e.pm = 8'h00;
      else if (m_halted)            e.pm = m_pc;
      else if (r_jmp || (r_jnz && !r_dz)) e.pm = {m_pc[7:4], r_ja};
      else                          e.pm = 8'((m_pc + 1) % 256);
      e.pc = m_pc; e.hold = m_halted; e.halted = m_halted; e.ack = m_stepping; e.cnt = m_cnt;
      sb.push_back(e);
      if (!r_rst) begin
         model_reset();
      end else begin
         running = !m_halted && !m_stepping;
         hit = running && r_bpen && m_armed && (m_pc == r_bpa);
         if (running) begin
            if (r_halt || hit) m_halted = 1;
         end else if (m_stepping) begin
            m_stepping = 0; m_halted = 1;
         end else if (!r_halt) begin
            if (r_run) m_halted = 0;
            else if (r_step && !m_prev_step) begin m_halted = 0; m_stepping = 1; end
         end
         if (hit) begin m_armed = 0; m_trig_pc = m_pc; end
         else if (!m_armed && m_pc != m_trig_pc) m_armed = 1;
         if (!e.hold && m_cnt < CMAX) m_cnt++;
         m_pc = e.pm;
         m_prev_step = r_step;
      end
   endtask

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every cycle the DUT presents a fetch address, compare it against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pm_addr",     32'(psif.pm_addr),     32'(e.pm));
            chk("pc",          32'(psif.pc),          32'(e.pc));
            chk("hold",        32'(psif.hold),        32'(e.hold));
            chk("halted",      32'(psif.halted),      32'(e.halted));
            chk("step_ack",    32'(psif.step_ack),    32'(e.ack));
            chk("instr_count", 32'(psif.instr_count), e.cnt);
         end
      end
   end

   task automatic run_to(input logic [7:0] target);
      for (int i = 0; i < 300 && m_pc != target; i++) tick();
   endtask

   initial begin
      idle(); r_bpen = 1'b0; r_bpa = 8'h00; model_reset();
      // reset, then free run across the wrap and counter saturation
      r_rst = 1'b0; tick(); tick(); r_rst = 1'b1;
      repeat (300) tick();
      // jumps stay in page
      r_rst = 1'b0; tick(); r_rst = 1'b1;
      run_to(8'h37);
      r_jmp = 1; r_ja = 4'h2; tick(); idle();
      run_to(8'h37);
      r_jnz = 1; r_dz = 1; r_ja = 4'h2; tick(); idle();
      r_jmp = 1; r_ja = 4'h7; tick(); idle();
      r_jnz = 1; r_dz = 0; r_ja = 4'h2; tick(); idle();
      tick();
      // halt, ignored jump, resume
      r_rst = 1'b0; tick(); r_rst = 1'b1;
      run_to(8'h10);
      r_halt = 1; tick(); idle();
      r_jmp = 1; r_ja = 4'h9; repeat (3) tick(); idle();
      r_run = 1; tick(); idle();
      repeat (3) tick();
      // halt landing on 0x20, two step edges, held step_req, simultaneous halt+run
      run_to(8'h1F);
      r_halt = 1; tick(); idle();
      tick();
      r_step = 1; repeat (5) tick(); r_step = 0; repeat (5) tick();
      r_step = 1; repeat (3) tick(); r_step = 0; tick();
      r_halt = 1; r_run = 1; repeat (3) tick(); idle();
      // reset during STEP
      r_step = 1; tick(); r_step = 0; r_rst = 1'b0; tick(); idle();
      repeat (3) tick();
      // breakpoint from reset, step off it, loop back in RUN
      r_bpen = 1; r_bpa = 8'h05;
      r_rst = 1'b0; tick(); r_rst = 1'b1;
      repeat (10) tick();
      r_step = 1; tick(); r_step = 0; repeat (3) tick();
      r_run = 1; tick(); idle();
      r_jmp = 1; r_ja = 4'h5; tick(); idle();
      repeat (4) tick();
      r_run = 1; tick(); idle(); r_bpen = 0;
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         r_rst  = ($urandom_range(63) != 0);
         r_jmp  = ($urandom_range(7) == 0);
         r_jnz  = ($urandom_range(5) == 0);
         r_dz   = 1'($urandom);
         r_ja   = 4'($urandom);
         r_halt = ($urandom_range(15) == 0);
         r_run  = ($urandom_range(7) == 0);
         if ($urandom_range(3) == 0) r_step = ~r_step;
         r_bpen = ($urandom_range(1) == 0);
         if ($urandom_range(31) == 0) r_bpa = 8'($urandom_range(15));
         tick();
      end
      idle();
      tick(); tick();
      @(negedge clk); #3;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
